// File: rtl/addsub_iter.sv
// Iterative two's-complement adder/subtractor: CHUNK bits per cycle with a
// registered carry between chunks, optional saturation on signed overflow.
module addsub_iter #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    input  logic             sat,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Ovfl,
    output logic             Neg,
    output logic             Zero,
    output logic [1:0]       state_dbg
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] bx_q, bx_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             sat_q, sat_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             ovfl_q, ovfl_d;
    logic             neg_q, neg_d;
    logic             zero_q, zero_d;

    logic [CHUNK-1:0] a_c, b_c;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] raw;
    logic             cin_msb, ovfl_raw;
    int               base;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        bx_d    = bx_q;
        res_d   = res_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sat_d   = sat_q;
        sum_d   = sum_q;
        ovfl_d  = ovfl_q;
        neg_d   = neg_q;
        zero_d  = zero_q;

        base      = int'(idx_q) * CHUNK;
        a_c       = a_q[base +: CHUNK];
        b_c       = bx_q[base +: CHUNK];
        chunk_sum = {1'b0, a_c} + {1'b0, b_c} + (CHUNK + 1)'(carry_q);
        raw       = res_q;
        raw[base +: CHUNK] = chunk_sum[CHUNK-1:0];
        // Carry into the top bit recovered from the top sum bit and its operands.
        cin_msb   = a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ chunk_sum[CHUNK-1];
        ovfl_raw  = cin_msb ^ chunk_sum[CHUNK];

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    a_d     = A;
                    bx_d    = B ^ {WIDTH{sub}};
                    sat_d   = sat;
                    carry_d = sub;
                    idx_d   = '0;
                end
            end
            RUN: begin
                res_d   = raw;
                carry_d = chunk_sum[CHUNK];
                idx_d   = idx_q + IW'(1);
                if (idx_q == IW'(N - 1)) begin
                    state_d = DONE;
                    ovfl_d  = ovfl_raw;
                    if (sat_q && ovfl_raw) begin
                        sum_d = raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                             : {1'b1, {(WIDTH-1){1'b0}}};
                    end else begin
                        sum_d = raw;
                    end
                    neg_d  = sum_d[WIDTH-1];
                    zero_d = (sum_d == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            bx_q    <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sat_q   <= 1'b0;
            sum_q   <= '0;
            ovfl_q  <= 1'b0;
            neg_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            bx_q    <= bx_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sat_q   <= sat_d;
            sum_q   <= sum_d;
            ovfl_q  <= ovfl_d;
            neg_q   <= neg_d;
            zero_q  <= zero_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign Sum       = sum_q;
    assign Ovfl      = ovfl_q;
    assign Neg       = neg_q;
    assign Zero      = zero_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_addsub_iter.sv
// Scoreboarded bench for addsub_iter: three instances (CHUNK 1, 4, 16) with
// per-instance expected queues and monitors; directed cases run on CHUNK=4.
module tb_addsub_iter;

    localparam int W = 16;

    logic          clk;
    logic          rst_n;
    logic [2:0]    start_v;
    logic [W-1:0]  a_in, b_in;
    logic          sub_in, sat_in;
    int            cyc;
    int            total;
    int            bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // {Ovfl, Neg, Zero, Sum}
    function automatic logic [W+2:0] pack(input logic [W-1:0] s, input logic o);
        return {o, s[W-1], (s == '0), s};
    endfunction

    function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s, input logic t);
        int ea = int'($signed(a));
        int eb = int'($signed(b));
        int r  = s ? ea - eb : ea + eb;
        logic o = (r > 32767) || (r < -32768);
        logic [W-1:0] res = r[W-1:0];
        if (t && o) res = (r > 0) ? 16'h7FFF : 16'h8000;
        return pack(res, o);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CH = (g == 0) ? 1 : (g == 1) ? 4 : 16;
        localparam int NI = W / CH;
        logic          busy, done, ovfl, neg, zero;
        logic [W-1:0]  sum;
        logic [1:0]    st;
        logic [W+2:0]  exp_q[$];
        int            iss_q[$];
        logic [W-1:0]  held;
        int            bcnt;

        addsub_iter #(.WIDTH(W), .CHUNK(CH)) dut (
            .clk(clk), .rst_n(rst_n), .start(start_v[g]),
            .A(a_in), .B(b_in), .sub(sub_in), .sat(sat_in),
            .busy(busy), .done(done), .Sum(sum), .Ovfl(ovfl),
            .Neg(neg), .Zero(zero), .state_dbg(st)
        );

        always @(negedge clk) begin
            if (!rst_n) begin
                held = '0;
                bcnt = 0;
            end else begin
                if (busy) bcnt++;
                if (done) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_done chunk=%0d got sum=%h want no done", CH, sum);
                    end else begin
                        logic [W+2:0] e;
                        int is;
                        e  = exp_q.pop_front();
                        is = iss_q.pop_front();
                        if ({ovfl, neg, zero, sum} !== e) begin
                            bad++;
                            $display("FAIL result chunk=%0d got {o,n,z,sum}=%b_%h want %b_%h",
                                     CH, {ovfl, neg, zero}, sum, e[W+2:W], e[W-1:0]);
                        end
                        total++;
                        if (cyc - is != NI + 1) begin
                            bad++;
                            $display("FAIL latency chunk=%0d got %0d want %0d", CH, cyc - is, NI + 1);
                        end
                        total++;
                        if (bcnt != NI) begin
                            bad++;
                            $display("FAIL busy_len chunk=%0d got %0d want %0d", CH, bcnt, NI);
                        end
                    end
                    bcnt = 0;
                    held = sum;
                end else begin
                    total++;
                    if (sum !== held) begin
                        bad++;
                        $display("FAIL sum_stable chunk=%0d got %h want %h", CH, sum, held);
                    end
                end
            end
        end
    end

    function automatic int pending();
        return g_dut[0].exp_q.size() + g_dut[1].exp_q.size() + g_dut[2].exp_q.size();
    endfunction

    task automatic drain(input int lim);
        int n = 0;
        while (pending() != 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (pending() != 0) begin
            bad++;
            $display("FAIL drain_timeout got pending=%0d want 0", pending());
            g_dut[0].exp_q.delete(); g_dut[0].iss_q.delete();
            g_dut[1].exp_q.delete(); g_dut[1].iss_q.delete();
            g_dut[2].exp_q.delete(); g_dut[2].iss_q.delete();
        end
    endtask

    task automatic push1(input logic [W-1:0] es, input logic eo);
        g_dut[1].exp_q.push_back(pack(es, eo));
        g_dut[1].iss_q.push_back(cyc);
    endtask

    task automatic set_ops(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s, input logic t);
        a_in = a; b_in = b; sub_in = s; sat_in = t;
    endtask

    // Single operation on the CHUNK=4 instance against a constant expectation.
    task automatic run1(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic t, input logic [W-1:0] es, input logic eo);
        @(negedge clk);
        set_ops(a, b, s, t);
        start_v[1] = 1'b1;
        push1(es, eo);
        @(negedge clk);
        start_v[1] = 1'b0;
        drain(40);
    endtask

    task automatic check_zero_outs(input string name);
        for (int k = 0; k < 3; k++) begin
            logic [W+4:0] v;
            case (k)
                0: v = {g_dut[0].busy, g_dut[0].done, g_dut[0].ovfl, g_dut[0].neg, g_dut[0].zero, g_dut[0].sum};
                1: v = {g_dut[1].busy, g_dut[1].done, g_dut[1].ovfl, g_dut[1].neg, g_dut[1].zero, g_dut[1].sum};
                default: v = {g_dut[2].busy, g_dut[2].done, g_dut[2].ovfl, g_dut[2].neg, g_dut[2].zero, g_dut[2].sum};
            endcase
            total++;
            if (v !== '0) begin
                bad++;
                $display("FAIL %s inst=%0d got outputs=%h want 0", name, k, v);
            end
        end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        rst_n = 1'b0; start_v = '0;
        set_ops('0, '0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_zero_outs("reset_state");
        rst_n = 1'b1;

        // Basic add, overflow with and without saturation, subtract edge cases.
        run1(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0);
        run1(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b1);
        run1(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1);
        run1(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1);
        run1(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1);
        run1(16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b0);
        run1(16'h0000, 16'h8000, 1'b1, 1'b0, 16'h8000, 1'b1);
        run1(16'h0000, 16'h8000, 1'b1, 1'b1, 16'h7FFF, 1'b1);
        run1(16'hFFFF, 16'h8000, 1'b1, 1'b0, 16'h7FFF, 1'b0);

        // Start pulses while RUN must not launch an extra operation.
        @(negedge clk);
        set_ops(16'h0100, 16'h0023, 1'b0, 1'b0);
        start_v[1] = 1'b1;
        push1(16'h0123, 1'b0);
        @(negedge clk);
        set_ops(16'h5555, 16'h1111, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        start_v[1] = 1'b0;
        drain(40);

        // Back-to-back: start held high, new operands presented at each done.
        begin
            logic [W-1:0] ta[4];
            logic [W-1:0] tb[4];
            logic [W-1:0] ts[4];
            ta = '{16'h0001, 16'h4000, 16'hF000, 16'h0FF0};
            tb = '{16'h0002, 16'h4000, 16'h1000, 16'h0F0F};
            ts = '{16'h0003, 16'h8000, 16'h0000, 16'h1EFF};
            @(negedge clk);
            start_v[1] = 1'b1;
            for (int i = 0; i < 4; i++) begin
                int n = 0;
                set_ops(ta[i], tb[i], 1'b0, 1'b0);
                push1(ts[i], i == 1);
                do begin
                    @(negedge clk);
                    n++;
                end while (!g_dut[1].done && n < 20);
                total++;
                if (!g_dut[1].done) begin
                    bad++;
                    $display("FAIL b2b_timeout op=%0d got no done want done", i);
                end
            end
            start_v[1] = 1'b0;
            drain(40);
        end

        // Reset two cycles into an operation discards it.
        @(negedge clk);
        set_ops(16'h1111, 16'h2222, 1'b0, 1'b0);
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero_outs("mid_reset");
        g_dut[1].exp_q.delete();
        g_dut[1].iss_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check_zero_outs("after_reset_idle");
        run1(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0);

        // Random sweep on all three chunk sizes against the arithmetic model.
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] a, b;
            logic s, t;
            a = ($urandom_range(0, 7) == 0) ? 16'h8000 : W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 16'h8000 : W'($urandom);
            if ($urandom_range(0, 9) == 0) b = 16'h7FFF;
            s = 1'($urandom_range(0, 1));
            t = 1'($urandom_range(0, 1));
            @(negedge clk);
            set_ops(a, b, s, t);
            start_v = 3'b111;
            g_dut[0].exp_q.push_back(model(a, b, s, t)); g_dut[0].iss_q.push_back(cyc);
            g_dut[1].exp_q.push_back(model(a, b, s, t)); g_dut[1].iss_q.push_back(cyc);
            g_dut[2].exp_q.push_back(model(a, b, s, t)); g_dut[2].iss_q.push_back(cyc);
            @(negedge clk);
            start_v = 3'b000;
            drain(40);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
